// File: rtl/adc_sampler_pkg.sv
// Shared types and default timing for the ADC0804-style sampler.
package adc_sampler_pkg;

    // Parallel data bus width of the converter.
    localparam int unsigned AdcWidth = 8;

    // Default timing, in system clock cycles (25 MHz).
    localparam int unsigned DefSampleDiv = 500;
    localparam int unsigned DefWrCycles  = 4;
    localparam int unsigned DefRdCycles  = 4;
    localparam int unsigned DefTimeout   = 2500;
    localparam int unsigned DefAvgLog2   = 2;

    // Conversion sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StConvert,
        StRead,
        StAccum
    } state_e;

    // Largest of three values; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/adc_sampler_sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to the idle-high value.
module adc_sampler_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw input one stage per clock.
    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    // Reset high so an idle active-low line is not mistaken for an event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/adc_sampler.sv
// Periodic ADC0804-style conversion sequencer with boxcar averaging and sticky status flags.
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DefSampleDiv,
    parameter int unsigned WR_CYCLES  = DefWrCycles,
    parameter int unsigned RD_CYCLES  = DefRdCycles,
    parameter int unsigned TIMEOUT    = DefTimeout,
    parameter int unsigned AVG_LOG2   = DefAvgLog2
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic [AdcWidth-1:0] adc_data,
    input  logic                adc_intr_n,
    output logic                adc_cs_n,
    output logic                adc_wr_n,
    output logic                adc_rd_n,
    output logic [AdcWidth-1:0] sample_out,
    output logic                sample_ready,
    input  logic                sample_ack,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int unsigned TickW  = $clog2(SAMPLE_DIV);
    localparam int unsigned CntMax = max3(WR_CYCLES, RD_CYCLES, TIMEOUT);
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned AccW   = AdcWidth + AVG_LOG2;
    localparam int unsigned SmpW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0]  WrLast   = CntW'(WR_CYCLES - 1);
    localparam logic [CntW-1:0]  RdLast   = CntW'(RD_CYCLES - 1);
    localparam logic [CntW-1:0]  ToLast   = CntW'(TIMEOUT - 1);
    localparam logic [SmpW-1:0]  SmpLast  = SmpW'((1 << AVG_LOG2) - 1);

    // Sample period divider.
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    // Sequencer state, shared phase counter (WR / CONVERT wait / RD).
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Averaging datapath.
    logic [AccW-1:0] acc_q, acc_d;
    logic [SmpW-1:0] smp_cnt_q, smp_cnt_d;
    logic [AdcWidth-1:0] sample_q, sample_d;

    // Registered strobes and status flags.
    logic cs_n_q, cs_n_d;
    logic wr_n_q, wr_n_d;
    logic rd_n_q, rd_n_d;
    logic ready_q, ready_d;
    logic overrun_q, overrun_d;
    logic timeout_q, timeout_d;

    logic intr_s;
    logic publish;
    logic timeout_evt;

    adc_sampler_sync2 u_intr_sync (
        .clk_i  (clock),
        .rst_ni (ctrl_reset),
        .d_i    (adc_intr_n),
        .q_o    (intr_s)
    );

    // Free-running tick; a tick seen outside IDLE is simply ignored by the sequencer.
    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end

    // Sequencer next state, phase counting and accumulation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        smp_cnt_d   = smp_cnt_q;
        sample_d    = sample_q;
        publish     = 1'b0;
        timeout_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == WrLast) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StConvert: begin
                // Conversion-done wins over a timeout landing in the same cycle.
                if (!intr_s) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else if (cnt_q == ToLast) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    timeout_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRead: begin
                // Data is only guaranteed valid late in the RD_n window.
                if (cnt_q == RdLast) begin
                    acc_d   = acc_q + AccW'(adc_data);
                    state_d = StAccum;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAccum: begin
                state_d = StIdle;
                if (smp_cnt_q == SmpLast) begin
                    publish   = 1'b1;
                    sample_d  = acc_q[AccW-1:AVG_LOG2];
                    acc_d     = '0;
                    smp_cnt_d = '0;
                end else begin
                    smp_cnt_d = smp_cnt_q + SmpW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes follow the next state so they change on the same edge as the state register.
    always_comb begin
        cs_n_d = !((state_d == StStart) || (state_d == StRead));
        wr_n_d = (state_d != StStart);
        rd_n_d = (state_d != StRead);
    end

    // Sticky flags: a set event beats a simultaneous ack, except that an ack
    // arriving with a fresh result consumes the old one without flagging overrun.
    always_comb begin
        ready_d   = ready_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        if (publish) begin
            ready_d = 1'b1;
            if (sample_ack) begin
                overrun_d = 1'b0;
            end else if (ready_q) begin
                overrun_d = 1'b1;
            end
        end else if (sample_ack) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (timeout_evt) begin
            timeout_d = 1'b1;
        end else if (sample_ack) begin
            timeout_d = 1'b0;
        end
    end

    // All state; asynchronous reset drops the strobes and any partial average at once.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            tick_cnt_q <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            smp_cnt_q  <= '0;
            sample_q   <= '0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            smp_cnt_q  <= smp_cnt_d;
            sample_q   <= sample_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_wr_n     = wr_n_q;
    assign adc_rd_n     = rd_n_q;
    assign sample_out   = sample_q;
    assign sample_ready = ready_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench: two samplers (passthrough and 4-sample average) share one ADC model.
module tb_adc_sampler;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic [7:0] adc_data;
    logic       adc_intr_n;
    logic       ack0, ack2;

    logic       cs0, wr0, rd0, rdy0, ovr0, to0;
    logic       cs2, wr2, rd2, rdy2, ovr2, to2;
    logic [7:0] out0, out2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int intr_delay = 20;
    bit model_hang = 1'b0;
    int intr_fall_cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    adc_sampler #(
        .SAMPLE_DIV (50),
        .WR_CYCLES  (4),
        .RD_CYCLES  (4),
        .TIMEOUT    (100),
        .AVG_LOG2   (0)
    ) u_avg0 (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .adc_data     (adc_data),
        .adc_intr_n   (adc_intr_n),
        .adc_cs_n     (cs0),
        .adc_wr_n     (wr0),
        .adc_rd_n     (rd0),
        .sample_out   (out0),
        .sample_ready (rdy0),
        .sample_ack   (ack0),
        .overrun      (ovr0),
        .timeout_err  (to0)
    );

    adc_sampler #(
        .SAMPLE_DIV (50),
        .WR_CYCLES  (4),
        .RD_CYCLES  (4),
        .TIMEOUT    (100),
        .AVG_LOG2   (2)
    ) u_avg2 (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .adc_data     (adc_data),
        .adc_intr_n   (adc_intr_n),
        .adc_cs_n     (cs2),
        .adc_wr_n     (wr2),
        .adc_rd_n     (rd2),
        .sample_out   (out2),
        .sample_ready (rdy2),
        .sample_ack   (ack2),
        .overrun      (ovr2),
        .timeout_err  (to2)
    );

    // ADC model: INTR_n falls intr_delay cycles after WR_n rises, and rises again on RD_n.
    initial begin
        adc_intr_n = 1'b1;
        forever begin
            @(posedge wr0);
            if (ctrl_reset && !model_hang) begin
                repeat (intr_delay) @(posedge clock);
                #2;
                adc_intr_n    = 1'b0;
                intr_fall_cyc = cyc;
                @(negedge rd0);
                adc_intr_n = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clock);
        ctrl_reset = 1'b0;
        ack0       = 1'b0;
        ack2       = 1'b0;
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b1;
        rel_cyc    = cyc;
    endtask

    // Poll at negedges until the chosen strobe of u_avg0 reaches level (bounded).
    task automatic wait_strobe(input bit is_rd, input logic level, input string name);
        int   n;
        logic v;
        n = 0;
        @(negedge clock);
        v = is_rd ? rd0 : wr0;
        while (v !== level && n < 400) begin
            @(negedge clock);
            n++;
            v = is_rd ? rd0 : wr0;
        end
        checks++;
        if (v !== level) begin
            errors++;
            $display("FAIL %s: strobe=%b after 400 cycles, expected %b", name, v, level);
        end
    endtask

    // One full conversion; returns at the negedge just after the publish edge.
    task automatic run_conv(input logic [7:0] d);
        adc_data = d;
        wait_strobe(1'b1, 1'b0, "conv_rd_low");
        wait_strobe(1'b1, 1'b1, "conv_rd_high");
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({cs0, wr0, rd0, cs2, wr2, rd2} !== 6'b111111) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 111111", {cs0, wr0, rd0, cs2, wr2, rd2});
        end
        checks++;
        if ({out0, out2} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sample_out: got %h, expected 0000", {out0, out2});
        end
        checks++;
        if ({rdy0, ovr0, to0, rdy2, ovr2, to2} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000", {rdy0, ovr0, to0, rdy2, ovr2, to2});
        end
        ctrl_reset = 1'b1;
        rel_cyc    = cyc;
    endtask

    task automatic test_single();
        int n;
        apply_reset();
        intr_delay = 20;
        adc_data   = 8'hA5;
        wait_strobe(1'b0, 1'b0, "single_wr_low");
        checks++;
        if (cyc - rel_cyc != 50) begin
            errors++;
            $display("FAIL first_start: started %0d cycles after reset, expected 50", cyc - rel_cyc);
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (wr0 === 1'b0) n++;
            else break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL wr_width: wr_n low %0d cycles, expected 4", n);
        end
        wait_strobe(1'b1, 1'b0, "single_rd_low");
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rd0 === 1'b0) n++;
            else break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rd_width: rd_n low %0d cycles, expected 4", n);
        end
        @(negedge clock);
        checks++;
        if (rdy0 !== 1'b1 || out0 !== 8'hA5) begin
            errors++;
            $display("FAIL single_result: ready=%b out=%h, expected ready=1 out=a5", rdy0, out0);
        end
        checks++;
        if (cyc - intr_fall_cyc != 8) begin
            errors++;
            $display("FAIL single_latency: %0d cycles after INTR_n, expected 8", cyc - intr_fall_cyc);
        end
        checks++;
        if (rdy2 !== 1'b0 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL single_side_flags: avg_ready=%b overrun=%b, expected 0 0", rdy2, ovr0);
        end
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ready=%b, expected 0", rdy0);
        end
    endtask

    task automatic test_average();
        logic [7:0] vals [4];
        vals[0] = 8'd10;
        vals[1] = 8'd20;
        vals[2] = 8'd30;
        vals[3] = 8'd41;
        apply_reset();
        intr_delay = 20;
        for (int i = 0; i < 4; i++) begin
            run_conv(vals[i]);
            if (i < 3) begin
                checks++;
                if (rdy2 !== 1'b0) begin
                    errors++;
                    $display("FAIL avg_early_ready: after conversion %0d ready=%b, expected 0",
                             i + 1, rdy2);
                end
            end
        end
        checks++;
        if (rdy2 !== 1'b1 || out2 !== 8'd25 || ovr2 !== 1'b0) begin
            errors++;
            $display("FAIL avg_result: ready=%b out=%0d overrun=%b, expected 1 25 0",
                     rdy2, out2, ovr2);
        end
        checks++;
        if (out0 !== 8'd41) begin
            errors++;
            $display("FAIL passthrough_last: out=%0d, expected 41", out0);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        intr_delay = 20;
        run_conv(8'h11);
        checks++;
        if (rdy0 !== 1'b1 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: ready=%b overrun=%b, expected 1 0", rdy0, ovr0);
        end
        run_conv(8'h22);
        checks++;
        if (rdy0 !== 1'b1 || ovr0 !== 1'b1 || out0 !== 8'h22) begin
            errors++;
            $display("FAIL overrun_second: ready=%b overrun=%b out=%h, expected 1 1 22",
                     rdy0, ovr0, out0);
        end
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        checks++;
        if (rdy0 !== 1'b0 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: ready=%b overrun=%b, expected 0 0", rdy0, ovr0);
        end
    endtask

    task automatic test_timeout();
        int t_start, c_e, s2, n;
        apply_reset();
        model_hang = 1'b1;
        wait_strobe(1'b0, 1'b0, "to_wr_low");
        t_start = cyc;
        wait_strobe(1'b0, 1'b1, "to_wr_high");
        c_e = cyc;
        checks++;
        if ({cs0, rd0} !== 2'b11) begin
            errors++;
            $display("FAIL convert_strobes: cs_n,rd_n=%b, expected 11", {cs0, rd0});
        end
        n = 0;
        while (to0 !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (cyc - c_e != 100) begin
            errors++;
            $display("FAIL timeout_latency: timeout_err after %0d cycles, expected 100", cyc - c_e);
        end
        checks++;
        if (rdy0 !== 1'b0 || {cs0, wr0, rd0} !== 3'b111) begin
            errors++;
            $display("FAIL timeout_idle: ready=%b strobes=%b, expected 0 111",
                     rdy0, {cs0, wr0, rd0});
        end
        wait_strobe(1'b0, 1'b0, "to_restart");
        s2 = cyc;
        checks++;
        if (s2 - t_start != 150) begin
            errors++;
            $display("FAIL timeout_restart: next START after %0d cycles, expected 150",
                     s2 - t_start);
        end
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        checks++;
        if (to0 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack: timeout_err=%b, expected 0", to0);
        end
        while (cyc < s2 + 103) @(negedge clock);
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        checks++;
        if (to0 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set_wins: timeout_err=%b, expected 1", to0);
        end
        model_hang = 1'b0;
    endtask

    task automatic test_simultaneous();
        int fc, n, s1;
        apply_reset();
        intr_delay = 20;
        run_conv(8'h33);
        adc_data = 8'h44;
        n = 0;
        @(negedge clock);
        while (adc_intr_n !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        fc = intr_fall_cyc;
        while (cyc < fc + 7) @(negedge clock);
        ack0 = 1'b1;
        @(negedge clock);
        ack0 = 1'b0;
        checks++;
        if (rdy0 !== 1'b1 || ovr0 !== 1'b0 || out0 !== 8'h44) begin
            errors++;
            $display("FAIL ack_with_publish: ready=%b overrun=%b out=%h, expected 1 0 44",
                     rdy0, ovr0, out0);
        end
        // Long INTR delay places the next tick inside READ.
        apply_reset();
        intr_delay = 40;
        adc_data   = 8'h5A;
        wait_strobe(1'b0, 1'b0, "drop_wr_low1");
        s1 = cyc;
        wait_strobe(1'b0, 1'b1, "drop_wr_high");
        wait_strobe(1'b0, 1'b0, "drop_wr_low2");
        checks++;
        if (cyc - s1 != 100) begin
            errors++;
            $display("FAIL tick_dropped: START spacing %0d cycles, expected 100", cyc - s1);
        end
        checks++;
        if (rdy0 !== 1'b1 || out0 !== 8'h5A) begin
            errors++;
            $display("FAIL drop_conv_result: ready=%b out=%h, expected 1 5a", rdy0, out0);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        intr_delay = 20;
        run_conv(8'h66);
        adc_data = 8'h99;
        wait_strobe(1'b1, 1'b0, "mid_rd_low");
        ctrl_reset = 1'b0;
        #1;
        checks++;
        if ({cs0, wr0, rd0, cs2, wr2, rd2} !== 6'b111111) begin
            errors++;
            $display("FAIL midread_strobes: got %b, expected 111111",
                     {cs0, wr0, rd0, cs2, wr2, rd2});
        end
        checks++;
        if ({out0, rdy0, ovr0, to0, rdy2, ovr2, to2} !== 14'h0000) begin
            errors++;
            $display("FAIL midread_outputs: out=%h flags=%b, expected 00 000000",
                     out0, {rdy0, ovr0, to0, rdy2, ovr2, to2});
        end
        @(negedge clock);
        ctrl_reset = 1'b1;
        rel_cyc    = cyc;
        run_conv(8'h3C);
        checks++;
        if (out0 !== 8'h3C || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: out=%h avg_ready=%b, expected 3c 0", out0, rdy2);
        end
        run_conv(8'h3C);
        run_conv(8'h40);
        run_conv(8'h40);
        checks++;
        if (rdy2 !== 1'b1 || out2 !== 8'h3E) begin
            errors++;
            $display("FAIL post_reset_avg: ready=%b out=%h, expected 1 3e", rdy2, out2);
        end
    endtask

    initial begin
        ctrl_reset = 1'b1;
        adc_data   = 8'h00;
        ack0       = 1'b0;
        ack2       = 1'b0;
        #1;
        ctrl_reset = 1'b0;
        test_reset();
        test_single();
        test_average();
        test_overrun();
        test_timeout();
        test_simultaneous();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
